typing_tracker: RTL and testbench

TYPING_TRACKER -- requirements
Module: typing_tracker

---
 rtl/typing_tracker_if.sv | 27 ++
 rtl/typing_tracker.sv | 102 ++++++++++
 tb/tb_typing_tracker.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/typing_tracker_if.sv
// typing_tracker_if: word/key inputs and game status outputs of the typing tracker.
interface typing_tracker_if #(
  parameter int WORD_LEN = 4,
  parameter int LETTER_W = 5
);
  logic [WORD_LEN*LETTER_W-1:0] currentWord;
  logic                         wordValid;
  logic [LETTER_W-1:0]          keystroke;
  logic                         keyReleased;
  logic                         strictMode;
  logic                         restart;
  logic                         wordComplete;
  logic                         mistake;
  logic                         gameOver;
  logic [3:0]                   letterIndex;
  logic [3:0]                   livesLeft;
  logic [15:0]                  wordsDone;
  logic                         busy;
  modport master (
    output currentWord, wordValid, keystroke, keyReleased, strictMode, restart,
    input  wordComplete, mistake, gameOver, letterIndex, livesLeft, wordsDone, busy
  );
  modport slave (
    input  currentWord, wordValid, keystroke, keyReleased, strictMode, restart,
    output wordComplete, mistake, gameOver, letterIndex, livesLeft, wordsDone, busy
  );
endinterface

// File: rtl/typing_tracker.sv
// typing_tracker: checks key presses against a latched word, tracking
// progress, lives, completed words and game over.
module typing_tracker #(
  parameter int WORD_LEN  = 4,
  parameter int LETTER_W  = 5,
  parameter int MAX_LIVES = 3
) (
  input logic            clk,
  input logic            rstN,
  typing_tracker_if.slave bus
);
  typedef enum logic [1:0] {WAIT_WORD, TYPING, OVER} state_t;
  localparam int WW = WORD_LEN * LETTER_W;
  state_t        r_state, w_state_nxt;
  logic          r_key_prev;
  logic [WW-1:0] r_word, w_word_nxt, w_sh;
  logic [3:0]    r_idx, w_idx_nxt, r_lives, w_lives_nxt;
  logic [15:0]   r_words, w_words_nxt;
  logic          r_complete, w_complete_nxt, r_mistake, w_mistake_nxt, r_over, w_over_nxt;
  logic          w_key_ev, w_last;
  logic [LETTER_W-1:0] w_letter;
  assign w_key_ev = bus.keyReleased & ~r_key_prev;
  // letter 0 sits in the MSBs, so shift the expected letter up to the top
  assign w_sh     = r_word << (r_idx * LETTER_W);
  assign w_letter = w_sh[WW-1 -: LETTER_W];
  assign w_last   = r_idx == 4'(WORD_LEN - 1);
  always_comb begin
    w_state_nxt    = r_state;
    w_word_nxt     = r_word;
    w_idx_nxt      = r_idx;
    w_lives_nxt    = r_lives;
    w_words_nxt    = r_words;
    w_complete_nxt = 1'b0;
    w_mistake_nxt  = 1'b0;
    w_over_nxt     = r_over;
    case (r_state)
      WAIT_WORD, TYPING: begin
        if (bus.wordValid) begin
          w_word_nxt  = bus.currentWord;
          w_idx_nxt   = '0;
          w_state_nxt = TYPING;
        end else if (r_state == TYPING && w_key_ev) begin
          if (bus.keystroke == w_letter) begin
            w_complete_nxt = w_last;
            w_idx_nxt      = w_last ? 4'd0 : r_idx + 4'd1;
            w_words_nxt    = (w_last && r_words != 16'hFFFF) ? r_words + 16'd1 : r_words;
            w_state_nxt    = w_last ? WAIT_WORD : TYPING;
          end else begin
            w_mistake_nxt = 1'b1;
            if (bus.strictMode || r_lives == 4'd1) begin
              w_lives_nxt = '0;
              w_over_nxt  = 1'b1;
              w_state_nxt = OVER;
            end else begin
              w_lives_nxt = r_lives - 4'd1;
            end
          end
        end
      end
      OVER: begin
        if (bus.restart) begin
          w_over_nxt  = 1'b0;
          w_lives_nxt = 4'(MAX_LIVES);
          w_words_nxt = '0;
          w_idx_nxt   = '0;
          w_state_nxt = WAIT_WORD;
        end
      end
      default: w_state_nxt = WAIT_WORD;
    endcase
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state    <= WAIT_WORD;
      r_key_prev <= 1'b0;
      r_word     <= '0;
      r_idx      <= '0;
      r_lives    <= 4'(MAX_LIVES);
      r_words    <= '0;
      r_complete <= 1'b0;
      r_mistake  <= 1'b0;
      r_over     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_key_prev <= bus.keyReleased;
      r_word     <= w_word_nxt;
      r_idx      <= w_idx_nxt;
      r_lives    <= w_lives_nxt;
      r_words    <= w_words_nxt;
      r_complete <= w_complete_nxt;
      r_mistake  <= w_mistake_nxt;
      r_over     <= w_over_nxt;
    end
  end
  assign bus.wordComplete = r_complete;
  assign bus.mistake      = r_mistake;
  assign bus.gameOver     = r_over;
  assign bus.letterIndex  = r_idx;
  assign bus.livesLeft    = r_lives;
  assign bus.wordsDone    = r_words;
  assign bus.busy         = r_state == TYPING;
endmodule

// File: tb/tb_typing_tracker.sv
// tb_typing_tracker: directed scenarios for typing_tracker with the word 3,1,20,19.
module tb_typing_tracker;
  localparam logic [19:0] WORD  = {5'd3, 5'd1, 5'd20, 5'd19};
  localparam logic [19:0] OTHER = {5'd9, 5'd9, 5'd9, 5'd9};
  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   errors = 0;
  int   checks = 0;
  typing_tracker_if #(.WORD_LEN(4), .LETTER_W(5)) bus();
  typing_tracker dut (.clk(clk), .rstN(rstN), .bus(bus));
  always #5 clk = ~clk;
  task automatic key(input logic [4:0] k);
    @(negedge clk);
    bus.keystroke   = k;
    bus.keyReleased = 1'b1;
    @(negedge clk);
    bus.keyReleased = 1'b0;
  endtask
  task automatic word_valid();
    @(negedge clk);
    bus.wordValid = 1'b1;
    @(negedge clk);
    bus.wordValid = 1'b0;
  endtask
  task automatic restart_pulse();
    @(negedge clk);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.letterIndex !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus.letterIndex); end
    checks++; if (bus.livesLeft !== 4'd3) begin errors++; $display("FAIL reset_lives: got %0d want 3", bus.livesLeft); end
    checks++; if (bus.wordsDone !== 16'd0) begin errors++; $display("FAIL reset_words: got %0h want 0", bus.wordsDone); end
    checks++; if ({bus.busy, bus.gameOver, bus.wordComplete, bus.mistake} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.gameOver, bus.wordComplete, bus.mistake}); end
    rstN = 1'b1;
  endtask
  task automatic test_word();
    logic [4:0] ks [4] = '{5'd3, 5'd1, 5'd20, 5'd19};
    logic [3:0] ix [4] = '{4'd1, 4'd2, 4'd3, 4'd0};
    word_valid();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL word_busy: got %b want 1", bus.busy); end
    for (int i = 0; i < 4; i++) begin
      key(ks[i]);
      checks++; if (bus.letterIndex !== ix[i]) begin errors++; $display("FAIL word_idx%0d: got %0d want %0d", i, bus.letterIndex, ix[i]); end
      checks++; if (bus.wordComplete !== (i == 3)) begin errors++; $display("FAIL word_complete%0d: got %b want %b", i, bus.wordComplete, i == 3); end
    end
    checks++; if (bus.wordsDone !== 16'd1) begin errors++; $display("FAIL word_count: got %0d want 1", bus.wordsDone); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL word_idle: got %b want 0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.wordComplete !== 1'b0) begin errors++; $display("FAIL word_pulse_end: got %b want 0", bus.wordComplete); end
  endtask
  task automatic test_lives();
    logic [4:0] ks [6] = '{5'd3, 5'd7, 5'd1, 5'd9, 5'd20, 5'd5};
    logic       ms [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] lv [6] = '{4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
    logic [3:0] ix [6] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3};
    bus.strictMode = 1'b0;
    word_valid();
    for (int i = 0; i < 6; i++) begin
      key(ks[i]);
      checks++; if (bus.mistake !== ms[i]) begin errors++; $display("FAIL lives_mistake%0d: got %b want %b", i, bus.mistake, ms[i]); end
      checks++; if (bus.livesLeft !== lv[i]) begin errors++; $display("FAIL lives_left%0d: got %0d want %0d", i, bus.livesLeft, lv[i]); end
      checks++; if (bus.letterIndex !== ix[i]) begin errors++; $display("FAIL lives_idx%0d: got %0d want %0d", i, bus.letterIndex, ix[i]); end
      checks++; if (bus.gameOver !== (i == 5)) begin errors++; $display("FAIL lives_over%0d: got %b want %b", i, bus.gameOver, i == 5); end
    end
    checks++; if (bus.wordsDone !== 16'd1) begin errors++; $display("FAIL lives_words_hold: got %0d want 1", bus.wordsDone); end
    restart_pulse();
    checks++; if ({bus.gameOver, bus.busy, bus.livesLeft, bus.wordsDone} !== {2'b00, 4'd3, 16'd0}) begin errors++; $display("FAIL lives_restart: got over=%b busy=%b lives=%0d words=%0d want 0 0 3 0", bus.gameOver, bus.busy, bus.livesLeft, bus.wordsDone); end
  endtask
  task automatic test_strict();
    bus.strictMode = 1'b1;
    word_valid();
    key(5'd4);
    checks++; if ({bus.mistake, bus.gameOver, bus.livesLeft, bus.letterIndex} !== {2'b11, 4'd0, 4'd0}) begin errors++; $display("FAIL strict_over: got mis=%b over=%b lives=%0d idx=%0d want 1 1 0 0", bus.mistake, bus.gameOver, bus.livesLeft, bus.letterIndex); end
    key(5'd3);
    checks++; if ({bus.mistake, bus.letterIndex, bus.gameOver} !== {1'b0, 4'd0, 1'b1}) begin errors++; $display("FAIL strict_key_ignored: got mis=%b idx=%0d over=%b want 0 0 1", bus.mistake, bus.letterIndex, bus.gameOver); end
    word_valid();
    checks++; if ({bus.busy, bus.gameOver} !== 2'b01) begin errors++; $display("FAIL strict_wv_ignored: got busy=%b over=%b want 0 1", bus.busy, bus.gameOver); end
    restart_pulse();
    checks++; if ({bus.gameOver, bus.busy, bus.livesLeft} !== {2'b00, 4'd3}) begin errors++; $display("FAIL strict_restart: got over=%b busy=%b lives=%0d want 0 0 3", bus.gameOver, bus.busy, bus.livesLeft); end
    bus.strictMode = 1'b0;
  endtask
  task automatic test_hold_and_reload();
    word_valid();
    @(negedge clk);
    bus.keystroke   = 5'd3;
    bus.keyReleased = 1'b1;
    repeat (50) @(negedge clk);
    checks++; if ({bus.letterIndex, bus.livesLeft} !== {4'd1, 4'd3}) begin errors++; $display("FAIL hold_one_event: got idx=%0d lives=%0d want 1 3", bus.letterIndex, bus.livesLeft); end
    bus.keyReleased = 1'b0;
    key(5'd1);
    checks++; if (bus.letterIndex !== 4'd2) begin errors++; $display("FAIL hold_next: got %0d want 2", bus.letterIndex); end
    @(negedge clk);
    bus.wordValid   = 1'b1;
    bus.keystroke   = 5'd5;
    bus.keyReleased = 1'b1;
    @(negedge clk);
    bus.wordValid   = 1'b0;
    bus.keyReleased = 1'b0;
    bus.currentWord = OTHER;
    checks++; if ({bus.letterIndex, bus.mistake, bus.livesLeft, bus.wordComplete} !== {4'd0, 1'b0, 4'd3, 1'b0}) begin errors++; $display("FAIL reload_discard: got idx=%0d mis=%b lives=%0d cmp=%b want 0 0 3 0", bus.letterIndex, bus.mistake, bus.livesLeft, bus.wordComplete); end
    key(5'd3); key(5'd1); key(5'd20); key(5'd19);
    checks++; if ({bus.wordComplete, bus.wordsDone} !== {1'b1, 16'd1}) begin errors++; $display("FAIL latched_word: got cmp=%b words=%0d want 1 1", bus.wordComplete, bus.wordsDone); end
    restart_pulse();
    checks++; if (bus.wordsDone !== 16'd1) begin errors++; $display("FAIL restart_ignored: got %0d want 1", bus.wordsDone); end
    bus.currentWord = WORD;
  endtask
  task automatic test_reset_mid();
    word_valid();
    key(5'd3); key(5'd1);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checks++; if ({bus.letterIndex, bus.busy, bus.wordsDone} !== {4'd0, 1'b0, 16'd0}) begin errors++; $display("FAIL async_reset: got idx=%0d busy=%b words=%0d want 0 0 0", bus.letterIndex, bus.busy, bus.wordsDone); end
    bus.keystroke   = 5'd3;
    bus.keyReleased = 1'b1;
    @(negedge clk);
    rstN = 1'b1;
    word_valid();
    repeat (3) @(negedge clk);
    checks++; if ({bus.letterIndex, bus.mistake, bus.wordComplete} !== {4'd0, 2'b00}) begin errors++; $display("FAIL held_key_after_reset: got idx=%0d mis=%b cmp=%b want 0 0 0", bus.letterIndex, bus.mistake, bus.wordComplete); end
    bus.keyReleased = 1'b0;
    key(5'd3);
    checks++; if (bus.letterIndex !== 4'd1) begin errors++; $display("FAIL key_after_reset: got %0d want 1", bus.letterIndex); end
  endtask
  task automatic test_saturation();
    force dut.r_words = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.r_words;
    @(negedge clk);
    checks++; if (bus.wordsDone !== 16'hFFFF) begin errors++; $display("FAIL sat_preload: got %0h want ffff", bus.wordsDone); end
    word_valid();
    key(5'd3); key(5'd1); key(5'd20); key(5'd19);
    checks++; if ({bus.wordComplete, bus.wordsDone} !== {1'b1, 16'hFFFF}) begin errors++; $display("FAIL sat_hold: got cmp=%b words=%0h want 1 ffff", bus.wordComplete, bus.wordsDone); end
  endtask
  initial begin
    bus.currentWord = WORD;
    bus.wordValid   = 1'b0;
    bus.keystroke   = '0;
    bus.keyReleased = 1'b0;
    bus.strictMode  = 1'b0;
    bus.restart     = 1'b0;
    test_reset();
    test_word();
    test_lives();
    test_strict();
    test_hold_and_reload();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
